read_pointer_control: RTL and testbench

Read-side pointer controller of the receive elastic buffer. It lives in the local clock domain. It synchronises the write-side Gray pointer, tracks buffer fill level, and advances the read address. It compensates clock drift by inserting SKP symbols when the buffer runs low and by asserting `delete_req` to the write side when the buffer runs high.

---
 rtl/read_pointer_control.sv | 132 +++++++++++++
 tb/tb_read_pointer_control.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_pointer_control.sv
// Read-side pointer controller of the receive elastic buffer: synchronises the
// write Gray pointer, tracks fill level, advances the read address and compensates drift.
module read_pointer_control #(
  parameter int DATA_WIDTH     = 10,
  parameter int BUFFER_DEPTH   = 16,
  parameter int LOW_THRESHOLD  = 4,
  parameter int HIGH_THRESHOLD = 12
) (
  input  logic                             read_clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            mem_data,
  input  logic [$clog2(BUFFER_DEPTH):0]    gray_write_pointer,
  output logic [$clog2(BUFFER_DEPTH):0]    read_address,
  output logic [$clog2(BUFFER_DEPTH):0]    gray_read_pointer,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             data_valid,
  output logic                             Skp_Inserted,
  output logic                             delete_req,
  output logic                             underflow
);

  localparam int ADDR = $clog2(BUFFER_DEPTH);
  localparam int PW   = ADDR + 1;

  localparam logic [PW-1:0]         LOW_TH  = PW'(LOW_THRESHOLD);
  localparam logic [PW-1:0]         HIGH_TH = PW'(HIGH_THRESHOLD);
  localparam logic [DATA_WIDTH-1:0] SKP_POS = DATA_WIDTH'(10'b0011111001);
  localparam logic [DATA_WIDTH-1:0] SKP_NEG = DATA_WIDTH'(10'b1100000110);

  function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int i = 0; i < PW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] bin_to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0]         wr_gray_meta_q;
  logic [PW-1:0]         wr_gray_sync_q;
  logic [PW-1:0]         read_address_q;
  logic [PW-1:0]         read_address_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic                  data_valid_q;
  logic                  data_valid_d;
  logic                  skp_inserted_q;
  logic                  skp_inserted_d;
  logic                  delete_req_q;
  logic                  delete_req_d;
  logic                  underflow_q;
  logic                  underflow_d;

  logic [PW-1:0] wr_gray_s;
  logic [PW-1:0] wr_bin_s;
  logic [PW-1:0] rd_gray_s;
  logic [PW-1:0] fill_s;
  logic          empty_s;
  logic          is_skp_s;

  // Two-flop synchroniser for the write-domain Gray pointer.
  always_ff @(posedge read_clk or posedge rst) begin
    if (rst) begin
      wr_gray_meta_q <= '0;
      wr_gray_sync_q <= '0;
    end else begin
      wr_gray_meta_q <= gray_write_pointer;
      wr_gray_sync_q <= wr_gray_meta_q;
    end
  end

  assign wr_gray_s = wr_gray_sync_q;
  assign wr_bin_s  = gray_to_bin(wr_gray_s);
  assign rd_gray_s = bin_to_gray(read_address_q);
  // Modulo-2^(ADDR+1) subtraction keeps fill correct across the wrap bit.
  assign fill_s    = wr_bin_s - read_address_q;
  assign empty_s   = (wr_gray_s == rd_gray_s);
  assign is_skp_s  = (mem_data == SKP_POS) || (mem_data == SKP_NEG);

  // Per-cycle read decision: empty, then SKP insertion, then normal advance.
  always_comb begin
    read_address_d = read_address_q;
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    skp_inserted_d = 1'b0;
    underflow_d    = 1'b0;
    delete_req_d   = (fill_s > HIGH_TH);
    if (empty_s) begin
      underflow_d = 1'b1;
    end else if (is_skp_s && (fill_s < LOW_TH) && !skp_inserted_q) begin
      data_out_d     = mem_data;
      data_valid_d   = 1'b1;
      skp_inserted_d = 1'b1;
    end else begin
      read_address_d = read_address_q + PW'(1);
      data_out_d     = mem_data;
      data_valid_d   = 1'b1;
    end
  end

  // Read pointer and registered output state.
  always_ff @(posedge read_clk or posedge rst) begin
    if (rst) begin
      read_address_q <= '0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      skp_inserted_q <= 1'b0;
      delete_req_q   <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      read_address_q <= read_address_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      skp_inserted_q <= skp_inserted_d;
      delete_req_q   <= delete_req_d;
      underflow_q    <= underflow_d;
    end
  end

  assign read_address      = read_address_q;
  assign gray_read_pointer = rd_gray_s;
  assign data_out          = data_out_q;
  assign data_valid        = data_valid_q;
  assign Skp_Inserted      = skp_inserted_q;
  assign delete_req        = delete_req_q;
  assign underflow         = underflow_q;

endmodule

// File: tb/tb_read_pointer_control.sv
// Directed self-checking bench for read_pointer_control; one task per scenario,
// each continuing from the pointer state the previous one left behind.
module tb_read_pointer_control;

  localparam logic [9:0] SKP1 = 10'b0011111001;
  localparam logic [9:0] SKP2 = 10'b1100000110;

  logic       read_clk = 1'b0;
  logic       rst;
  logic [9:0] mem_data;
  logic [4:0] gray_write_pointer;
  logic [4:0] read_address;
  logic [4:0] gray_read_pointer;
  logic [9:0] data_out;
  logic       data_valid;
  logic       Skp_Inserted;
  logic       delete_req;
  logic       underflow;

  logic [9:0] mem [16];
  int checks   = 0;
  int failures = 0;

  read_pointer_control dut (
    .read_clk           (read_clk),
    .rst                (rst),
    .mem_data           (mem_data),
    .gray_write_pointer (gray_write_pointer),
    .read_address       (read_address),
    .gray_read_pointer  (gray_read_pointer),
    .data_out           (data_out),
    .data_valid         (data_valid),
    .Skp_Inserted       (Skp_Inserted),
    .delete_req         (delete_req),
    .underflow          (underflow)
  );

  always #5 read_clk = ~read_clk;
  assign mem_data = mem[read_address[3:0]];

  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  task automatic set_wp(input logic [4:0] wp);
    gray_write_pointer = wp ^ (wp >> 1);
  endtask

  task automatic fill_mem(input logic [9:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  task automatic test_reset();
    fill_mem(10'h155);
    gray_write_pointer = 5'd0;
    rst = 1'b1;
    #2;
    checks++;
    if ({read_address, gray_read_pointer, data_out, data_valid, Skp_Inserted, delete_req, underflow} !== 25'd0) begin
      failures++;
      $display("FAIL reset_values got ra=%0d grp=%0d do=%h dv=%b skp=%b del=%b uf=%b exp all 0",
               read_address, gray_read_pointer, data_out, data_valid, Skp_Inserted, delete_req, underflow);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({underflow, data_valid, read_address} !== {1'b1, 1'b0, 5'd0}) begin
        failures++;
        $display("FAIL reset_empty got uf=%b dv=%b ra=%0d exp uf=1 dv=0 ra=0", underflow, data_valid, read_address);
      end
    end
  endtask

  task automatic test_streaming();
    set_wp(5'd8);
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (underflow !== 1'b1 || data_valid !== 1'b0) begin
        failures++;
        $display("FAIL stream_sync_latency got uf=%b dv=%b exp uf=1 dv=0", underflow, data_valid);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if ({read_address, data_out, data_valid, underflow, delete_req} !== {5'(i), 10'h155, 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL stream_read got ra=%0d do=%h dv=%b uf=%b del=%b exp ra=%0d do=155 dv=1 uf=0 del=0",
                 read_address, data_out, data_valid, underflow, delete_req, i);
      end
    end
    tick();
    checks++;
    if ({read_address, data_out, data_valid, underflow} !== {5'd8, 10'h155, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL stream_drained got ra=%0d do=%h dv=%b uf=%b exp ra=8 do=155 dv=0 uf=1",
               read_address, data_out, data_valid, underflow);
    end
  endtask

  task automatic test_skp_insertion();
    mem[8] = SKP1;
    mem[9] = 10'h0AA;
    set_wp(5'd10);
    tick();
    tick();
    tick();
    checks++;
    if ({read_address, data_out, data_valid, Skp_Inserted, underflow} !== {5'd8, SKP1, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL skp_insert got ra=%0d do=%h dv=%b skp=%b uf=%b exp ra=8 do=0f9 dv=1 skp=1 uf=0",
               read_address, data_out, data_valid, Skp_Inserted, underflow);
    end
    tick();
    checks++;
    if ({read_address, data_out, data_valid, Skp_Inserted} !== {5'd9, SKP1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL skp_no_reinsert got ra=%0d do=%h dv=%b skp=%b exp ra=9 do=0f9 dv=1 skp=0",
               read_address, data_out, data_valid, Skp_Inserted);
    end
    tick();
    checks++;
    if ({read_address, data_out, Skp_Inserted} !== {5'd10, 10'h0AA, 1'b0}) begin
      failures++;
      $display("FAIL skp_follow got ra=%0d do=%h skp=%b exp ra=10 do=0aa skp=0", read_address, data_out, Skp_Inserted);
    end
    tick();
    checks++;
    if (underflow !== 1'b1 || read_address !== 5'd10) begin
      failures++;
      $display("FAIL skp_drained got uf=%b ra=%0d exp uf=1 ra=10", underflow, read_address);
    end
  endtask

  task automatic test_delete_req();
    fill_mem(10'h155);
    mem[10] = SKP2;
    set_wp(5'd23);
    tick();
    tick();
    checks++;
    if (delete_req !== 1'b0) begin
      failures++;
      $display("FAIL delete_before_sync got %b exp 0", delete_req);
    end
    tick();
    checks++;
    if ({delete_req, read_address, data_out, Skp_Inserted, data_valid} !== {1'b1, 5'd11, SKP2, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL delete_skp_high got del=%b ra=%0d do=%h skp=%b dv=%b exp del=1 ra=11 do=306 skp=0 dv=1",
               delete_req, read_address, data_out, Skp_Inserted, data_valid);
    end
    tick();
    checks++;
    if (delete_req !== 1'b0 || read_address !== 5'd12) begin
      failures++;
      $display("FAIL delete_drop got del=%b ra=%0d exp del=0 ra=12", delete_req, read_address);
    end
    for (int i = 13; i <= 23; i++) begin
      tick();
      checks++;
      if (read_address !== 5'(i) || data_valid !== 1'b1) begin
        failures++;
        $display("FAIL delete_drain got ra=%0d dv=%b exp ra=%0d dv=1", read_address, data_valid, i);
      end
    end
    tick();
    checks++;
    if (underflow !== 1'b1) begin
      failures++;
      $display("FAIL delete_empty got uf=%b exp 1", underflow);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_ra;
    logic [4:0] prev_ra;
    for (int i = 0; i < 16; i++) mem[i] = 10'h100 + 10'(i);
    set_wp(5'd2);
    tick();
    tick();
    for (int k = 1; k <= 11; k++) begin
      tick();
      exp_ra  = 5'(23 + k);
      prev_ra = 5'(22 + k);
      checks++;
      if ({read_address, data_out, data_valid, underflow} !== {exp_ra, 10'h100 + 10'(prev_ra[3:0]), 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL wrap_read got ra=%0d do=%h dv=%b uf=%b exp ra=%0d do=%h dv=1 uf=0",
                 read_address, data_out, data_valid, underflow, exp_ra, 10'h100 + 10'(prev_ra[3:0]));
      end
    end
    tick();
    checks++;
    if (underflow !== 1'b1 || read_address !== 5'd2 || gray_read_pointer !== 5'd3) begin
      failures++;
      $display("FAIL wrap_empty got uf=%b ra=%0d grp=%0d exp uf=1 ra=2 grp=3", underflow, read_address, gray_read_pointer);
    end
  endtask

  task automatic test_full_buffer();
    set_wp(5'd18);
    tick();
    tick();
    for (int i = 3; i <= 18; i++) begin
      tick();
      checks++;
      if ({read_address, data_valid, underflow, delete_req} !== {5'(i), 1'b1, 1'b0, (i < 7) ? 1'b1 : 1'b0}) begin
        failures++;
        $display("FAIL full_read got ra=%0d dv=%b uf=%b del=%b exp ra=%0d dv=1 uf=0 del=%0d",
                 read_address, data_valid, underflow, delete_req, i, (i < 7) ? 1 : 0);
      end
    end
  endtask

  task automatic test_low_boundary();
    mem[2] = SKP1;
    set_wp(5'd22);
    tick();
    tick();
    tick();
    checks++;
    if ({read_address, data_out, Skp_Inserted, data_valid} !== {5'd19, SKP1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL low_threshold_no_insert got ra=%0d do=%h skp=%b dv=%b exp ra=19 do=0f9 skp=0 dv=1",
               read_address, data_out, Skp_Inserted, data_valid);
    end
    tick();
    tick();
    tick();
    checks++;
    if (read_address !== 5'd22) begin
      failures++;
      $display("FAIL low_drain got ra=%0d exp 22", read_address);
    end
  endtask

  task automatic test_async_reset();
    set_wp(5'd28);
    tick();
    tick();
    tick();
    checks++;
    if (read_address !== 5'd23 || data_valid !== 1'b1) begin
      failures++;
      $display("FAIL async_pre got ra=%0d dv=%b exp ra=23 dv=1", read_address, data_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({read_address, gray_read_pointer, data_out, data_valid, Skp_Inserted, delete_req, underflow} !== 25'd0) begin
      failures++;
      $display("FAIL async_reset got ra=%0d grp=%0d do=%h dv=%b skp=%b del=%b uf=%b exp all 0",
               read_address, gray_read_pointer, data_out, data_valid, Skp_Inserted, delete_req, underflow);
    end
    gray_write_pointer = 5'd0;
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if ({underflow, data_valid, read_address, data_out} !== {1'b1, 1'b0, 5'd0, 10'd0}) begin
      failures++;
      $display("FAIL async_release got uf=%b dv=%b ra=%0d do=%h exp uf=1 dv=0 ra=0 do=000",
               underflow, data_valid, read_address, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skp_insertion();
    test_delete_req();
    test_wrap();
    test_full_buffer();
    test_low_boundary();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
